// File: rtl/fft_8p_pkg.sv
// Shared definitions for the 8-point FFT datapath blocks.
//   N_POINTS / LOG2_N  : frame size and index width
//   DEF_WIDTH          : default real/imag sample width (two's complement)
//   DEF_Q_LENGTH       : default number of fractional bits (Q16.16)
//   bitrev3()          : 3-bit bit reversal, the DIT input ordering
package fft_8p_pkg;

    localparam int N_POINTS     = 8;
    localparam int LOG2_N       = 3;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_Q_LENGTH = 16;

    function automatic logic [LOG2_N-1:0] bitrev3(input logic [LOG2_N-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft_8p_frame_buffer_if.sv
// Serial sample stream into the FFT frame buffer.
//   s_valid : sample valid (driven by the producer)
//   s_ready : buffer can take a sample this cycle (driven by the buffer)
//   s_real  : sample real part
//   s_img   : sample imaginary part
//   s_last  : marks the 8th sample of a frame
// Handshake: a sample transfers on every rising clk edge where s_valid and
// s_ready are both high. While s_valid is high and s_ready is low the
// producer holds s_real/s_img/s_last unchanged; s_ready may depend
// combinationally on buffer state but never on s_valid.
interface fft_8p_frame_buffer_if
    import fft_8p_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_real;
    logic [WIDTH-1:0] s_img;
    logic             s_last;

    modport master (
        output s_valid,
        output s_real,
        output s_img,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_real,
        input  s_img,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/fft_8p_frame_bank.sv
// One frame bank: 8 lanes of (real, img) registers plus a full flag.
//   clk, reset          : clock, synchronous active-high reset (clears data and flag)
//   wr_en, wr_lane      : write one lane this cycle
//   wr_real, wr_img     : lane write data
//   set_full, clr_full  : mark the bank complete / released (set wins)
//   full                : bank holds a complete frame
//   lanes_real/img      : all lanes packed, lane k at [k*WIDTH +: WIDTH]
module fft_8p_frame_bank
    import fft_8p_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [LOG2_N-1:0]         wr_lane,
    input  logic [WIDTH-1:0]          wr_real,
    input  logic [WIDTH-1:0]          wr_img,
    input  logic                      set_full,
    input  logic                      clr_full,
    output logic                      full,
    output logic [N_POINTS*WIDTH-1:0] lanes_real,
    output logic [N_POINTS*WIDTH-1:0] lanes_img
);

    logic [WIDTH-1:0] mem_real [N_POINTS];
    logic [WIDTH-1:0] mem_img  [N_POINTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_POINTS; k++) begin
                mem_real[k] <= '0;
                mem_img[k]  <= '0;
            end
            full <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_real[wr_lane] <= wr_real;
                mem_img[wr_lane]  <= wr_img;
            end
            // set and clear never target the same bank in one cycle: the
            // writer only fills an empty bank, the reader only frees a full one.
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

    always_comb begin
        lanes_real = '0;
        lanes_img  = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            lanes_real[k*WIDTH +: WIDTH] = mem_real[k];
            lanes_img[k*WIDTH +: WIDTH]  = mem_img[k];
        end
    end

endmodule

// File: rtl/fft_8p_frame_buffer.sv
// Ping-pong frame buffer in front of the 8-point FFT core. Collects serial
// samples into 8-lane frames and presents each complete frame in parallel,
// held until the consumer takes it.
//   clk, reset          : clock, synchronous active-high reset
//   s (slave modport)   : serial sample stream (s_valid/s_ready/s_real/s_img/s_last)
//   x_real, x_img       : frame lanes, lane k at [k*WIDTH +: WIDTH] -> xk
//   frame_valid         : x_real/x_img hold a complete frame
//   frame_ready         : consumer takes the frame on this edge
//   err_short           : pulse in the cycle s_last is accepted before index 7
//   err_long            : pulse in the cycle index 7 is accepted without s_last
module fft_8p_frame_buffer
    import fft_8p_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int Q_LENGTH    = DEF_Q_LENGTH,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    fft_8p_frame_buffer_if.slave      s,
    output logic [N_POINTS*WIDTH-1:0] x_real,
    output logic [N_POINTS*WIDTH-1:0] x_img,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic                      err_short,
    output logic                      err_long
);

    // Q_LENGTH only documents the number format; data passes through untouched.
    if (Q_LENGTH < 0 || Q_LENGTH > WIDTH) begin : g_bad_q_length
        $error("fft_8p_frame_buffer: Q_LENGTH out of range for WIDTH");
    end

    logic [LOG2_N-1:0]         wr_idx;
    logic [LOG2_N-1:0]         wr_lane;
    logic                      wr_bank;
    logic                      rd_bank;
    logic                      accept;
    logic                      last_slot;
    logic                      release_frame;
    logic [1:0]                full;
    logic [1:0]                bank_wr_en;
    logic [1:0]                bank_set_full;
    logic [1:0]                bank_clr_full;
    logic [N_POINTS*WIDTH-1:0] bank_real [2];
    logic [N_POINTS*WIDTH-1:0] bank_img  [2];

    // s_ready and frame_valid are forced low during reset so nothing stale
    // leaks out before the synchronous clear has taken effect.
    assign s.s_ready   = !reset && !full[wr_bank];
    assign frame_valid = !reset && full[rd_bank];
    assign x_real      = reset ? '0 : bank_real[rd_bank];
    assign x_img       = reset ? '0 : bank_img[rd_bank];

    always_comb begin
        accept        = s.s_valid && s.s_ready;
        last_slot     = (wr_idx == LOG2_N'(N_POINTS - 1));
        release_frame = frame_valid && frame_ready;
        wr_lane       = BIT_REVERSE ? bitrev3(wr_idx) : wr_idx;

        bank_wr_en    = {accept && wr_bank, accept && !wr_bank};
        bank_set_full = bank_wr_en & {2{last_slot}};
        bank_clr_full = {release_frame && rd_bank, release_frame && !rd_bank};

        err_short     = accept && !last_slot && s.s_last;
        err_long      = accept && last_slot && !s.s_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (accept) begin
                // A short frame restarts at lane 0 of the same bank; its
                // stale lanes are simply overwritten by the next frame.
                if (last_slot || s.s_last) begin
                    wr_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
                if (last_slot) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (release_frame) begin
                rd_bank <= !rd_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_8p_frame_bank #(
            .WIDTH (WIDTH)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (bank_wr_en[b]),
            .wr_lane    (wr_lane),
            .wr_real    (s.s_real),
            .wr_img     (s.s_img),
            .set_full   (bank_set_full[b]),
            .clr_full   (bank_clr_full[b]),
            .full       (full[b]),
            .lanes_real (bank_real[b]),
            .lanes_img  (bank_img[b])
        );
    end

endmodule

// File: tb/tb_fft_8p_frame_buffer.sv
// Directed bench for fft_8p_frame_buffer. Two instances share one stimulus
// stream: dut (lanes in natural order) and dut_br (bit-reversed lanes).
module tb_fft_8p_frame_buffer;
    import fft_8p_pkg::*;

    localparam int W  = 32;
    localparam int VW = N_POINTS * W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus and DUT wiring ----------------
    logic          s_valid;
    logic [W-1:0]  s_real;
    logic [W-1:0]  s_img;
    logic          s_last;
    logic          frame_ready;

    logic [VW-1:0] x_real, x_img, br_x_real, br_x_img;
    logic          frame_valid, err_short, err_long;
    logic          br_frame_valid, br_err_short, br_err_long;

    fft_8p_frame_buffer_if #(.WIDTH(W)) sif ();
    fft_8p_frame_buffer_if #(.WIDTH(W)) sif_br ();

    assign sif.s_valid    = s_valid;
    assign sif.s_real     = s_real;
    assign sif.s_img      = s_img;
    assign sif.s_last     = s_last;
    assign sif_br.s_valid = s_valid;
    assign sif_br.s_real  = s_real;
    assign sif_br.s_img   = s_img;
    assign sif_br.s_last  = s_last;

    fft_8p_frame_buffer #(.WIDTH(W), .Q_LENGTH(16), .BIT_REVERSE(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (sif.slave),
        .x_real      (x_real),
        .x_img       (x_img),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    fft_8p_frame_buffer #(.WIDTH(W), .Q_LENGTH(16), .BIT_REVERSE(1'b1)) dut_br (
        .clk         (clk),
        .reset       (reset),
        .s           (sif_br.slave),
        .x_real      (br_x_real),
        .x_img       (br_x_img),
        .frame_valid (br_frame_valid),
        .frame_ready (frame_ready),
        .err_short   (br_err_short),
        .err_long    (br_err_long)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks     = 0;
    int n_pass       = 0;
    int n_stall      = 0;
    int n_err_short  = 0;
    int n_err_long   = 0;
    logic err_long_at_accept;

    // Error pulses are combinational in the accepting cycle; count them mid-cycle.
    always @(negedge clk) begin
        if (err_short) n_err_short++;
        if (err_long)  n_err_long++;
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expected packed lanes: lane l holds base + (sample index stored there),
    // negated for the imaginary part. Bit-reversed lane order written out by hand.
    function automatic logic [VW-1:0] lanes(input int base, input bit neg, input bit br);
        int br_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        logic [VW-1:0] v;
        int s;
        v = '0;
        for (int l = 0; l < 8; l++) begin
            s = base + (br ? br_tab[l] : l);
            v[l*W +: W] = neg ? -s : s;
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and return just after the edge that accepts it.
    task automatic send(input int re, input int im, input bit last);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_img   = im;
        s_last  = last;
        while (!sif.s_ready && guard < 20) begin
            step();
            guard++;
            n_stall++;
        end
        if (!sif.s_ready) begin
            n_checks++;
            $error("FAIL send_timeout: observed s_ready=0 for %0d cycles, expected 1", guard);
        end
        err_long_at_accept = err_long;
        step();
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish by 200000, expected finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int es0, el0;
        s_valid = 1'b0; s_real = '0; s_img = '0; s_last = 1'b0;
        frame_ready = 1'b0;
        err_long_at_accept = 1'b0;
        reset = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_s_ready",     VW'(sif.s_ready), '0);
        check("rst_frame_valid", VW'(frame_valid), '0);
        check("rst_x_real",      x_real, '0);
        check("rst_x_img",       x_img, '0);
        check("rst_errs",        VW'({err_short, err_long}), '0);
        reset = 1'b0;
        step();
        check("s_ready_after_reset", VW'(sif.s_ready), VW'(1));

        // Single frame, frame_ready held high
        frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(k, -k, k == 7);
            if (k == 6) check("t1_fv_before_last", VW'(frame_valid), '0);
        end
        s_valid = 1'b0;
        check("t1_frame_valid", VW'(frame_valid), VW'(1));
        check("t1_x_real",      x_real, lanes(0, 0, 0));
        check("t1_x_img",       x_img, lanes(0, 1, 0));
        check("t1_br_x_real",   br_x_real, lanes(0, 0, 1));
        check("t1_br_x_img",    br_x_img, lanes(0, 1, 1));
        check("t1_no_stall",    VW'(n_stall), '0);
        check("t1_no_errs",     VW'(n_err_short + n_err_long), '0);
        step();
        check("t1_released",    VW'(frame_valid), '0);
        frame_ready = 1'b0;

        // Back-pressure: two frames fill both banks, third must wait
        for (int f = 1; f <= 2; f++) begin
            for (int k = 0; k < 8; k++) send(16*f + k, -(16*f + k), k == 7);
        end
        check("t2_s_ready_low", VW'(sif.s_ready), '0);
        check("t2_fv_a",        VW'(frame_valid), VW'(1));
        check("t2_x_a",         x_real, lanes(16, 0, 0));
        check("t2_no_stall",    VW'(n_stall), '0);
        s_real = 48; s_img = -48; s_last = 1'b0;
        repeat (3) step();
        check("t2_hold_s_ready", VW'(sif.s_ready), '0);
        check("t2_hold_x_a",     x_real, lanes(16, 0, 0));
        check("t2_hold_img_a",   x_img, lanes(16, 1, 0));
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("t2_fv_b",         VW'(frame_valid), VW'(1));
        check("t2_x_b",          x_real, lanes(32, 0, 0));
        check("t2_s_ready_back", VW'(sif.s_ready), VW'(1));
        for (int k = 0; k < 8; k++) send(48 + k, -(48 + k), k == 7);
        s_valid = 1'b0;
        check("t2_full_again",   VW'(sif.s_ready), '0);
        check("t2_still_b",      x_real, lanes(32, 0, 0));
        frame_ready = 1'b1;
        step();
        check("t2_x_c",          x_real, lanes(48, 0, 0));
        check("t2_img_c",        x_img, lanes(48, 1, 0));
        step();
        check("t2_drained",      VW'(frame_valid), '0);
        frame_ready = 1'b0;

        // Short frame then a proper one
        es0 = n_err_short;
        el0 = n_err_long;
        for (int k = 0; k < 5; k++) send(100 + k, -(100 + k), k == 4);
        s_valid = 1'b0;
        step();
        check("t3_err_short_once", VW'(n_err_short - es0), VW'(1));
        check("t3_no_frame",       VW'(frame_valid), '0);
        for (int k = 0; k < 8; k++) send(200 + k, -(200 + k), k == 7);
        s_valid = 1'b0;
        check("t3_fv",             VW'(frame_valid), VW'(1));
        check("t3_x_real",         x_real, lanes(200, 0, 0));
        check("t3_x_img",          x_img, lanes(200, 1, 0));
        check("t3_no_err_long",    VW'(n_err_long - el0), '0);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("t3_released",       VW'(frame_valid), '0);

        // Long frame: 8 samples, no s_last
        es0 = n_err_short;
        el0 = n_err_long;
        for (int k = 0; k < 8; k++) send(300 + k, -(300 + k), 1'b0);
        s_valid = 1'b0;
        check("t4_err_long_on_8th", VW'(err_long_at_accept), VW'(1));
        check("t4_fv",              VW'(frame_valid), VW'(1));
        check("t4_x_real",          x_real, lanes(300, 0, 0));
        check("t4_br_x_real",       br_x_real, lanes(300, 0, 1));
        step();
        check("t4_err_long_once",   VW'(n_err_long - el0), VW'(1));
        check("t4_no_err_short",    VW'(n_err_short - es0), '0);

        // Reset while a frame is held and another is half collected
        for (int k = 0; k < 5; k++) send(400 + k, -(400 + k), 1'b0);
        s_valid = 1'b0;
        check("t5_pre_fv", VW'(frame_valid), VW'(1));
        reset = 1'b1;
        step();
        check("t5_rst_s_ready", VW'(sif.s_ready), '0);
        check("t5_rst_fv",      VW'(frame_valid), '0);
        check("t5_rst_x_real",  x_real, '0);
        check("t5_rst_x_img",   x_img, '0);
        reset = 1'b0;
        step();
        check("t5_post_fv",     VW'(frame_valid), '0);
        check("t5_post_x_real", x_real, '0);
        for (int k = 0; k < 8; k++) begin
            send(500 + k, -(500 + k), k == 7);
            if (k == 6) check("t5_fv_before_last", VW'(frame_valid), '0);
        end
        s_valid = 1'b0;
        check("t5_fv",          VW'(frame_valid), VW'(1));
        check("t5_x_real",      x_real, lanes(500, 0, 0));
        check("t5_x_img",       x_img, lanes(500, 1, 0));
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("t5_released",    VW'(frame_valid), '0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_8p_frame_buffer.md
Name: fft_8p_frame_buffer

Overview:
- Upstream neighbour of the 8-point radix-2 DIT FFT core.
- Accepts a serial stream of complex Q16.16 samples over a valid/ready handshake and assembles them into 8-sample frames.
- Presents each complete frame in parallel on the FFT core's x0..x7 inputs, held stable until the downstream side accepts it.
- Ping-pong double buffering sustains one sample per clock while the previous frame is being consumed.

Parameters:
- WIDTH, 32, bit width of each real/imaginary sample (two's complement, Q_LENGTH fractional bits; data is passed through, no arithmetic).
- Q_LENGTH, 16, fractional bits; documentation only, no effect on logic.
- BIT_REVERSE, 0, 0 = sample k stored in lane k; 1 = sample k stored in lane bitrev3(k).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  buffer can accept a sample this cycle.
- s_real  in  WIDTH  input sample real part.
- s_img  in  WIDTH  input sample imaginary part.
- s_last  in  1  marks the 8th (final) sample of a frame.
- x_real  out  8*WIDTH  frame real parts; lane k at [k*WIDTH +: WIDTH], maps to xk_real.
- x_img  out  8*WIDTH  frame imaginary parts; same packing.
- frame_valid  out  1  x_real/x_img hold a complete frame.
- frame_ready  in  1  downstream accepts the frame.
- err_short  out  1  one-cycle pulse: s_last seen before sample index 7.
- err_long  out  1  one-cycle pulse: index-7 sample accepted without s_last.

Behaviour:
- Storage:
  - Two banks (0, 1), each 8 lanes x (real, img), all registers.
  - Per-bank full flag.
  - wr_bank, rd_bank pointers (1 bit each).
  - wr_idx counter (3 bits).
- Reset (synchronous): all bank data 0; full flags 0; wr_bank = rd_bank = 0; wr_idx = 0.
  - Output values in reset: s_ready = 0 during reset, 1 in the first cycle after; frame_valid = 0; x_real = x_img = 0; err_short = err_long = 0.
- Handshake rules:
  - s_ready = !reset && !full[wr_bank].
  - A sample is accepted when s_valid && s_ready.
  - Upstream must hold data stable while s_valid && !s_ready.
- On accept:
  - Write lane L of bank wr_bank, where L = wr_idx (or bitrev3(wr_idx) when BIT_REVERSE = 1).
  - If wr_idx == 7: set full[wr_bank], toggle wr_bank, set wr_idx to 0. If s_last == 0, also pulse err_long; the frame is still committed.
  - Else if s_last == 1 (short frame): set wr_idx to 0, pulse err_short. The partial frame is discarded: the bank is not marked full, and its stale lanes are overwritten by the next frame.
  - Else: increment wr_idx.
- Frame output:
  - frame_valid = full[rd_bank].
  - x_real/x_img = bank[rd_bank] contents, muxed directly from registers with no extra stage.
  - Values are stable while frame_valid && !frame_ready.
  - On frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank.
- Latency and throughput:
  - Sample 7 accepted on cycle N -> frame_valid = 1 on cycle N+1.
  - Sustained rate is 1 sample/clk with no bubbles, provided each frame is accepted within 8 cycles of frame_valid rising.
  - If both banks are full, s_ready = 0 until a frame is accepted. s_ready returns to 1 the cycle after that acceptance.
- Simultaneous events: committing a frame into one bank and releasing the other bank in the same cycle are independent; both take effect. The write bank and read bank are never the same full bank.
- Reset mid-frame or mid-hold: all state is discarded. No frame_valid is asserted for a partially collected frame.
- Width rules: pure storage; no truncation, rounding or sign handling.
- Downstream timing: the FFT core adds 1 cycle of latency. Delaying frame_valid to align with the FFT output is the top level's job, not this block's.

Decomposition:
- Shared package fft_8p_pkg holds:
  - N_POINTS = 8 and LOG2_N = 3.
  - The bitrev3 function.
  - Default WIDTH/Q_LENGTH constants, so this block and the FFT core agree.
- One natural sub-module, fft_8p_frame_bank: a single 8-lane write-addressable register bank with full flag, instantiated twice.
- Pointer/handshake logic stays in the top.

Test Plan:
- Single frame, BIT_REVERSE = 0:
  - Stimulus: continuous s_valid, samples real = k, img = -k for k = 0..7, s_last on k = 7, frame_ready = 1.
  - Response: frame_valid high exactly 1 cycle after sample 7. Lane k real = k, img = -k. No error pulses.
- Back-pressure:
  - Stimulus: frame_ready = 0; stream 3 frames back to back.
  - Response: s_ready drops after 16 samples, and both frames stay stable. Raising frame_ready for 1 cycle releases frame 1 and presents frame 2; s_ready returns the next cycle; frame 3 completes into the freed bank.
- Short frame:
  - Stimulus: s_last on the 5th sample (idx 4), then a proper 8-sample frame.
  - Response: err_short pulses 1 cycle. No frame_valid for the short one. The next frame's lanes are exactly the new 8 samples.
- Long frame:
  - Stimulus: 8 samples with no s_last.
  - Response: err_long pulses on the 8th accept. frame_valid asserts with those 8 samples.
- BIT_REVERSE = 1:
  - Stimulus: samples 0..7.
  - Response: lanes hold 0,4,2,6,1,5,3,7.
- Reset mid-frame:
  - Stimulus: after 5 accepted samples, assert reset 1 cycle, then send a full frame.
  - Response: outputs are 0 during reset. The first frame_valid carries only the post-reset samples.
